clk_rst_ctrl: RTL and testbench

//  Reset sequencer for the clk_pll wrapper. Runs on the 50 MHz PLL reference clock.

---
 rtl/clk_rst_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/clk_rst_ctrl.sv | 166 ++++++++++++++++
 tb/tb_clk_rst_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_rst_pkg
//  Brief    : Shared types, default constants and width helper for the
//             clk_pll reset sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package clk_rst_pkg;

    // One-hot sequencer states
    typedef enum logic [4:0] {
        PLL_RST   = 5'b00001,
        WAIT_LOCK = 5'b00010,
        STABLE    = 5'b00100,
        RUN       = 5'b01000,
        FAIL      = 5'b10000
    } state_t;

    localparam int c_DEF_PLL_RST_CYCLES     = 64;
    localparam int c_DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int c_DEF_LOCK_TIMEOUT       = 65536;
    localparam int c_DEF_MAX_RETRY          = 3;

    // Bits needed to hold the values 0 .. n-1, never less than one bit
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : clk_rst_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Brief    : Two-flop synchroniser, asynchronously reset to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/clk_rst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_rst_ctrl
//  Brief    : PLL reset sequencer - pulses the PLL reset, qualifies lock and
//             releases the system reset, retrying a bounded number of times.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_rst_ctrl
    import clk_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = c_DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES = c_DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT       = c_DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY          = c_DEF_MAX_RETRY
) (
    input  logic                             refclk,
    input  logic                             rst,
    input  logic                             locked,
    output logic                             pll_rst,
    output logic                             sys_rst,
    output logic                             ready,
    output logic                             lock_err,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt
);

    localparam int c_RST_W = cnt_width(PLL_RST_CYCLES);
    localparam int c_STB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int c_TO_W  = cnt_width(LOCK_TIMEOUT);
    localparam int c_RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_STB_W-1:0] c_STB_LAST = c_STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(MAX_RETRY);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_RST_W-1:0]   r_rst_cnt;
    logic [c_RST_W-1:0]   w_rst_cnt_nxt;
    logic [c_STB_W-1:0]   r_stb_cnt;
    logic [c_STB_W-1:0]   w_stb_cnt_nxt;
    logic [c_TO_W-1:0]    r_to_cnt;
    logic [c_TO_W-1:0]    w_to_cnt_nxt;
    logic [c_RTY_W-1:0]   r_retry;
    logic [c_RTY_W-1:0]   w_retry_nxt;
    logic [c_RTY_W-1:0]   w_retry_inc;
    logic                 w_locked_s;
    logic                 w_timeout;

    logic                 r_pll_rst;
    logic                 r_sys_rst;
    logic                 r_ready;
    logic                 r_lock_err;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (w_locked_s)
    );

    assign w_timeout   = ((r_state == WAIT_LOCK) || (r_state == STABLE)) &&
                         (r_to_cnt == c_TO_LAST);
    assign w_retry_inc = (r_retry == c_RTY_MAX) ? r_retry : r_retry + 1'b1;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= PLL_RST;
            r_rst_cnt <= '0;
            r_stb_cnt <= '0;
            r_to_cnt  <= '0;
            r_retry   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= w_rst_cnt_nxt;
            r_stb_cnt <= w_stb_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_retry   <= w_retry_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = '0;
        w_stb_cnt_nxt = '0;
        w_to_cnt_nxt  = r_to_cnt;
        w_retry_nxt   = r_retry;

        case (r_state)
            PLL_RST: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_state_nxt  = WAIT_LOCK;
                    w_to_cnt_nxt = '0;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (r_to_cnt != c_TO_LAST) begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
                if (w_locked_s) begin
                    w_state_nxt = STABLE;
                end
            end
            STABLE: begin
                if (r_to_cnt != c_TO_LAST) begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
                // Any drop restarts the qualification window but keeps the timeout running
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_stb_cnt == c_STB_LAST) begin
                    w_state_nxt = RUN;
                    w_retry_nxt = '0;
                end else begin
                    w_stb_cnt_nxt = r_stb_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = PLL_RST;
                end
            end
            FAIL: begin
                w_state_nxt = FAIL;
            end
            default: begin
                w_state_nxt = PLL_RST;
            end
        endcase

        // Timeout overrides a same-cycle STABLE->RUN completion
        if (w_timeout) begin
            w_retry_nxt   = w_retry_inc;
            w_to_cnt_nxt  = '0;
            w_stb_cnt_nxt = '0;
            w_state_nxt   = (w_retry_inc >= c_RTY_MAX) ? FAIL : PLL_RST;
        end
    end

    // Moore outputs decoded from the next state so they move with the state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_pll_rst  <= 1'b1;
            r_sys_rst  <= 1'b1;
            r_ready    <= 1'b0;
            r_lock_err <= 1'b0;
        end else begin
            r_pll_rst  <= (w_state_nxt == PLL_RST) || (w_state_nxt == FAIL);
            r_sys_rst  <= (w_state_nxt != RUN);
            r_ready    <= (w_state_nxt == RUN);
            r_lock_err <= r_lock_err || (w_state_nxt == FAIL);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign lock_err  = r_lock_err;
    assign retry_cnt = r_retry;

endmodule : clk_rst_ctrl
`default_nettype wire

// File: tb/tb_clk_rst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_rst_ctrl
//  Brief    : Directed self-checking bench for clk_rst_ctrl with small
//             parameters (4 / 8 / 32 / 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_rst_ctrl;
    import clk_rst_pkg::*;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_err;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    logic flag;

    always #5 refclk = ~refclk;

    clk_rst_ctrl #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT       (32),
        .MAX_RETRY          (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .lock_err  (lock_err),
        .retry_cnt (retry_cnt)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"},  32'(pll_rst),   32'd1);
        chk({tag, "_sys_rst"},  32'(sys_rst),   32'd1);
        chk({tag, "_ready"},    32'(ready),     32'd0);
        chk({tag, "_lock_err"}, 32'(lock_err),  32'd0);
        chk({tag, "_retry"},    32'(retry_cnt), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b0;
        tick(2);
        chk_reset_vals("por");

        // Nominal bring-up: pll_rst high 4 cycles, RUN 11 edges after locked rises in WAIT_LOCK
        rst = 1'b0;
        tick(3);
        chk("nom_pll_rst_held", 32'(pll_rst), 32'd1);
        tick(1);
        chk("nom_pll_rst_fall", 32'(pll_rst), 32'd0);
        chk("nom_sys_rst_wait", 32'(sys_rst), 32'd1);
        tick(3);
        locked = 1'b1;
        tick(10);
        chk("nom_sys_rst_before_run", 32'(sys_rst), 32'd1);
        tick(1);
        chk("nom_sys_rst_run", 32'(sys_rst),   32'd0);
        chk("nom_ready_run",   32'(ready),     32'd1);
        chk("nom_retry_run",   32'(retry_cnt), 32'd0);

        // Lock loss in RUN: sys_rst reasserts on the third edge, then a full pll_rst pulse
        locked = 1'b0;
        tick(2);
        chk("loss_sys_rst_edge2", 32'(sys_rst), 32'd0);
        tick(1);
        chk("loss_sys_rst_edge3", 32'(sys_rst), 32'd1);
        chk("loss_pll_rst_edge3", 32'(pll_rst), 32'd1);
        chk("loss_ready_edge3",   32'(ready),   32'd0);
        chk("loss_retry",         32'(retry_cnt), 32'd0);
        tick(3);
        chk("loss_pll_rst_held", 32'(pll_rst), 32'd1);
        tick(1);
        chk("loss_pll_rst_fall", 32'(pll_rst), 32'd0);

        // Chatter while in WAIT_LOCK: 5 high, 3 low, then steady high -> RUN 19 edges later
        locked = 1'b1;
        flag   = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick(1);
            if (k == 5) locked = 1'b0;
            if (k == 8) locked = 1'b1;
            if (k == 10) chk("chat_back_to_wait", 32'(dut.r_state), 32'(WAIT_LOCK));
            if (sys_rst !== 1'b1 || ready !== 1'b0) flag = 1'b1;
        end
        chk("chat_no_early_release", 32'(flag), 32'd0);
        tick(1);
        chk("chat_sys_rst_run", 32'(sys_rst), 32'd0);
        chk("chat_ready_run",   32'(ready),   32'd1);

        // Timeout then retry: 32 cycles without lock in WAIT_LOCK
        locked = 1'b0;
        tick(7);
        chk("to_enter_wait", 32'(pll_rst), 32'd0);
        tick(31);
        chk("to_pll_rst_pre",  32'(pll_rst),   32'd0);
        chk("to_retry_pre",    32'(retry_cnt), 32'd0);
        tick(1);
        chk("to_pll_rst_post", 32'(pll_rst),   32'd1);
        chk("to_retry_post",   32'(retry_cnt), 32'd1);
        tick(3);
        chk("to_pulse_held", 32'(pll_rst), 32'd1);
        tick(1);
        chk("to_pulse_fall", 32'(pll_rst), 32'd0);
        locked = 1'b1;
        tick(10);
        chk("to_retry_kept",   32'(retry_cnt), 32'd1);
        tick(1);
        chk("to_relock_run",   32'(sys_rst),   32'd0);
        chk("to_retry_clear",  32'(retry_cnt), 32'd0);

        // Permanent no-lock: two timeouts end in FAIL
        locked = 1'b0;
        tick(7);
        chk("nl_enter_wait", 32'(pll_rst), 32'd0);
        tick(32);
        chk("nl_retry1", 32'(retry_cnt), 32'd1);
        chk("nl_pll_rst1", 32'(pll_rst), 32'd1);
        tick(4);
        chk("nl_wait2", 32'(pll_rst), 32'd0);
        tick(31);
        chk("nl_lock_err_pre", 32'(lock_err), 32'd0);
        tick(1);
        chk("nl_lock_err",  32'(lock_err),     32'd1);
        chk("nl_pll_rst",   32'(pll_rst),      32'd1);
        chk("nl_sys_rst",   32'(sys_rst),      32'd1);
        chk("nl_ready",     32'(ready),        32'd0);
        chk("nl_retry2",    32'(retry_cnt),    32'd2);
        chk("nl_state",     32'(dut.r_state),  32'(FAIL));
        flag = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick(1);
            if (lock_err !== 1'b1 || pll_rst !== 1'b1 || sys_rst !== 1'b1 ||
                ready !== 1'b0 || retry_cnt !== 2'd2) flag = 1'b1;
        end
        chk("nl_hold_stable", 32'(flag),        32'd0);
        chk("nl_hold_state",  32'(dut.r_state), 32'(FAIL));

        // Asynchronous rst in FAIL, between edges
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_fail");
        @(negedge refclk);
        rst = 1'b0;
        tick(3);
        chk("rf_pll_rst_held", 32'(pll_rst), 32'd1);
        tick(1);
        chk("rf_pll_rst_fall", 32'(pll_rst), 32'd0);

        // Asynchronous rst mid-STABLE, then restart with locked held high
        locked = 1'b1;
        tick(6);
        chk("rs_in_stable", 32'(dut.r_state), 32'(STABLE));
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_stable");
        @(negedge refclk);
        rst = 1'b0;
        tick(12);
        chk("rs_sys_rst_pre", 32'(sys_rst), 32'd1);
        tick(1);
        chk("rs_sys_rst_run", 32'(sys_rst), 32'd0);
        chk("rs_ready_run",   32'(ready),   32'd1);
        chk("rs_pll_rst_run", 32'(pll_rst), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_rst_ctrl
`default_nettype wire
